// File: rtl/hemaia_multi_clock_divider.sv
// Multi-channel integer clock divider: per-channel divisor handshake, switching only at
// period boundaries, 50 % duty for odd divisors, bypass/gating for D<=1, cross-channel align.

module tc_clk_mux2 (
   input  logic clk0,
   input  logic clk1,
   input  logic sel,
   output logic clk_out
);
   assign clk_out = sel ? clk1 : clk0;
endmodule

module tc_clk_and2 (
   input  logic a,
   input  logic b,
   output logic clk_out
);
   assign clk_out = a & b;
endmodule

// Latch-based integrated clock gate; enable is captured while the clock is low.
module tc_clk_gating (
   input  logic clk_in,
   input  logic en,
   input  logic test_en,
   output logic clk_out
);
   logic en_latch;

   always_latch begin
      if (!clk_in) begin
         en_latch <= en | test_en;
      end
   end

   assign clk_out = clk_in & en_latch;
endmodule

module hemaia_clk_div_channel #(
   parameter int unsigned     DivW     = 8,
   parameter logic [DivW-1:0] DivReset = DivW'(1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            test_en,
   input  logic [DivW-1:0] divisor,
   input  logic            divisor_valid,
   output logic            divisor_ready,
   input  logic            align,
   output logic [DivW-1:0] divisor_q,
   output logic            clk_out
);
   logic [DivW-1:0] cnt_q, cnt_d;
   logic [DivW-1:0] div_q, div_d;
   logic [DivW-1:0] pend_q, pend_d;
   logic            ready_q, ready_d;
   logic            accept, apply;
   logic            raw;
   logic            d1_q, d2_q;
   logic            odd_q, bypass_q, gate_en_q;
   logic            clk_odd, clk_div, clk_sel;

   // Low for the first floor(D/2) counts of a period, high for the rest.
   assign raw = (cnt_q >= (div_q >> 1));

   always_comb begin
      cnt_d   = cnt_q;
      div_d   = div_q;
      pend_d  = pend_q;
      ready_d = ready_q;
      accept  = divisor_valid & ready_q;
      apply   = ~ready_q & (align | (cnt_q == '0));

      if (accept) begin
         pend_d  = divisor;
         ready_d = 1'b0;
      end
      if (apply) begin
         div_d   = pend_q;
         ready_d = 1'b1;
      end

      // Counter range follows the divisor being applied on this very edge.
      if (align) begin
         cnt_d = '0;
      end else if ((div_d <= DivW'(1)) || (cnt_q >= (div_d - DivW'(1)))) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + DivW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         div_q   <= DivReset;
         pend_q  <= '0;
         ready_q <= 1'b1;
         d1_q    <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         pend_q  <= pend_d;
         ready_q <= ready_d;
         d1_q    <= raw;
      end
   end

   // Clock-path selects are retimed to the falling edge so they only move while clk_i is low.
   always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         d2_q      <= 1'b1;
         odd_q     <= DivReset[0];
         bypass_q  <= (DivReset <= DivW'(1));
         gate_en_q <= (DivReset != '0);
      end else begin
         d2_q      <= d1_q;
         odd_q     <= div_q[0];
         bypass_q  <= (div_q <= DivW'(1));
         gate_en_q <= (div_q != '0);
      end
   end

   tc_clk_and2 i_odd_and (
      .a       (d1_q),
      .b       (d2_q),
      .clk_out (clk_odd)
   );

   tc_clk_mux2 i_parity_mux (
      .clk0    (d1_q),
      .clk1    (clk_odd),
      .sel     (odd_q),
      .clk_out (clk_div)
   );

   // D==0 also routes clk_i so that scan mode sees a toggling clock behind the gate.
   tc_clk_mux2 i_bypass_mux (
      .clk0    (clk_div),
      .clk1    (clk_i),
      .sel     (bypass_q),
      .clk_out (clk_sel)
   );

   tc_clk_gating i_gate (
      .clk_in  (clk_sel),
      .en      (gate_en_q),
      .test_en (test_en),
      .clk_out (clk_out)
   );

   assign divisor_ready = ready_q;
   assign divisor_q     = div_q;
endmodule

module hemaia_multi_clock_divider #(
   parameter int unsigned NumChannels      = 4,
   parameter int unsigned MaxDivisionWidth = 8,
   parameter int unsigned DefaultDivision  = 1
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  test_en_i,
   input  logic [NumChannels*MaxDivisionWidth-1:0] divisor_i,
   input  logic [NumChannels-1:0]                divisor_valid_i,
   output logic [NumChannels-1:0]                divisor_ready_o,
   input  logic                                  align_i,
   input  logic [NumChannels-1:0]                align_mask_i,
   output logic [NumChannels*MaxDivisionWidth-1:0] divisor_q_o,
   output logic [NumChannels-1:0]                clk_o
);
   localparam int unsigned     DivW     = MaxDivisionWidth;
   localparam logic [DivW-1:0] DivReset = DivW'(DefaultDivision);

   for (genvar g = 0; g < NumChannels; g++) begin : gen_ch
      hemaia_clk_div_channel #(
         .DivW     (DivW),
         .DivReset (DivReset)
      ) i_ch (
         .clk_i         (clk_i),
         .rst_ni        (rst_ni),
         .test_en       (test_en_i),
         .divisor       (divisor_i[g*DivW +: DivW]),
         .divisor_valid (divisor_valid_i[g]),
         .divisor_ready (divisor_ready_o[g]),
         .align         (align_i & align_mask_i[g]),
         .divisor_q     (divisor_q_o[g*DivW +: DivW]),
         .clk_out       (clk_o[g])
      );
   end
endmodule

// File: doc/hemaia_multi_clock_divider.md
HEMAIA_MULTI_CLOCK_DIVIDER -- requirements
Module: hemaia_multi_clock_divider

Interface
REQ-001 SHALL have parameter NumChannels, default 4: number of independent divided clock outputs (1..16).
REQ-002 SHALL have parameter MaxDivisionWidth, default 8: divisor width per channel.
REQ-003 SHALL have parameter DefaultDivision, default 1: divisor loaded into every channel at reset.
REQ-004 SHALL have port clk_i, input, 1: source clock.
REQ-005 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port test_en_i, input, 1: forces all clock gates open (scan).
REQ-007 SHALL have port divisor_i, input, NumChannels x MaxDivisionWidth: requested divisor per channel.
REQ-008 SHALL have port divisor_valid_i, input, NumChannels: per-channel request valid.
REQ-009 SHALL have port divisor_ready_o, output, NumChannels: per-channel request ready.
REQ-010 SHALL have port align_i, input, 1: single-cycle phase-alignment strobe.
REQ-011 SHALL have port align_mask_i, input, NumChannels: channels affected by align_i.
REQ-012 SHALL have port divisor_q_o, output, NumChannels x MaxDivisionWidth: currently applied divisor.
REQ-013 SHALL have port clk_o, output, NumChannels: divided clocks.

Function
REQ-014 Each channel SHALL own a counter cnt, 0..D-1 on posedge clk_i, wrapping to 0 after D-1; D = applied divisor; for D<=1, cnt holds 0.
REQ-015 raw SHALL be 0 while cnt < floor(D/2), else 1; registered on posedge (d1), d1 re-registered on negedge (d2).
REQ-016 D even >=2: clk_o = d1; high D/2, low D/2 input periods.
REQ-017 D odd >=3: clk_o = d1 AND d2; period D, high exactly D/2 input periods (50 % duty).
REQ-018 D==1: clk_o SHALL be clk_i via glitch-free clock mux; D==0: clk_o SHALL be gated low unless test_en_i=1.
REQ-019 Even/odd and bypass selection SHALL use tech clock-mux/gate cells only, never plain logic.
REQ-020 Handshake: request accepted on posedge where divisor_valid_i & divisor_ready_o; divisor_i captured that edge; divisor_ready_o drops to 0 the next cycle.
REQ-021 Pending divisor SHALL be applied on the first posedge with cnt==0 (period boundary) after acceptance, never mid-period; divisor_q_o and cnt range update that edge.
REQ-022 divisor_ready_o SHALL reassert the cycle after application; at most one pending request per channel.
REQ-023 Channels SHALL be fully independent except via align_i.
REQ-024 align_i=1 SHALL clear cnt of every masked channel to 0 on that posedge, taking priority over normal increment; unmasked channels unaffected.
REQ-025 If a masked channel has a pending divisor at align_i, it SHALL be applied on the same edge and ready reasserts next cycle.
REQ-026 Masked channels with equal D SHALL produce identical, phase-aligned clk_o from the align edge + 1 cycle onward.
REQ-027 divisor_valid_i with divisor_ready_o=0 SHALL be ignored (no overwrite of pending value).

Reset
REQ-028 On rst_ni=0: cnt=0, divisor_q_o=DefaultDivision all channels, pending cleared, divisor_ready_o=all 1, d1=d2=1.
REQ-029 Reset asserted mid-period or with a pending request SHALL discard the request; first post-reset period starts at cnt=0.
REQ-030 During reset clk_o SHALL be 1 for D>=2, clk_i for D==1, 0 for D==0 (test_en_i=0).

Verification
REQ-031 Reset, DefaultDivision=1 -> all clk_o equal clk_i; divisor_ready_o=all 1.
REQ-032 Ch0 request D=4 at cnt arbitrary -> applied at next cnt==0; clk_o period 4, high 2 cycles; ready low until cycle after apply.
REQ-033 Ch1 D=5 -> period 5, high 2.5 input periods, no runt pulse at switch from D=2.
REQ-034 Ch2 D=0 -> clk_o held low; with test_en_i=1 clk_o toggles.
REQ-035 Ch0 D=3, ch1 D=3 mis-phased; align_i with mask 0b0011 -> both cnt=0 same edge, identical clk_o thereafter; ch2/ch3 unaffected.
REQ-036 Second valid while pending (D=6 then D=8) -> D=8 ignored, D=6 applied; rst_ni pulse with pending -> divisor_q_o=DefaultDivision.
